// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver FSM states, word size and default
// timing constants (in clk_sys cycles at 50 MHz) also used by the transmitter side.
package ws2812_pkg;

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_IDLE,
      ST_HIGH,
      ST_LOW
   } state_t;

   localparam int GRB_BITS           = 24;
   localparam int CNT_W              = 16;
   localparam int DEF_T_THRESH_CLK   = 30;
   localparam int DEF_T_MIN_HIGH_CLK = 5;
   localparam int DEF_T_MAX_HIGH_CLK = 100;
   localparam int DEF_T_RESET_CLK    = 2500;
   localparam int DEF_MAX_PIXELS     = 109;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous LED line; adds two cycles of latency.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 one-wire receiver: decodes GRB pixels and latch frames from din.
// Define WS2812_RX_FORWARD_EN to build the cascade output (dout) that passes on pixels 1..N.
//
// state | meaning
// SYNC  | lost or unknown framing; waiting for T_RESET_CLK of continuous low
// IDLE  | framed, line low, waiting for the first high of a bit
// HIGH  | measuring the high part of a bit
// LOW   | measuring the low part of a bit; a long low is the latch
module ws2812_rx
   import ws2812_pkg::*;
#(
   parameter int T_THRESH_CLK   = DEF_T_THRESH_CLK,
   parameter int T_MIN_HIGH_CLK = DEF_T_MIN_HIGH_CLK,
   parameter int T_MAX_HIGH_CLK = DEF_T_MAX_HIGH_CLK,
   parameter int T_RESET_CLK    = DEF_T_RESET_CLK,
   parameter int MAX_PIXELS     = DEF_MAX_PIXELS
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        din,
   output logic        pix_valid,
   output logic [23:0] pix_data,
   output logic [7:0]  pix_index,
   output logic        frame_done,
   output logic [7:0]  frame_pixels,
   output logic        bit_err,
   output logic        overflow,
   output logic        dout
);

   localparam logic [CNT_W-1:0] THRESH = CNT_W'(T_THRESH_CLK);
   localparam logic [CNT_W-1:0] MIN_H  = CNT_W'(T_MIN_HIGH_CLK);
   localparam logic [CNT_W-1:0] MAX_H1 = CNT_W'(T_MAX_HIGH_CLK + 1);
   localparam logic [CNT_W-1:0] RST_L  = CNT_W'(T_RESET_CLK);
   localparam logic [CNT_W-1:0] MAXP   = CNT_W'(MAX_PIXELS);
   localparam logic [4:0]       LAST_BIT = 5'(GRB_BITS - 1);

   logic             din_s;
   state_t           state;
   logic [CNT_W-1:0] hcnt, lcnt, pix_cnt;
   logic [CNT_W-1:0] hcnt_inc, lcnt_inc;
   logic [4:0]       bit_cnt;
   logic [23:0]      shreg, sh_next;
   logic             bit_val, pix_done_now, latch_now;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (din),
      .q     (din_s)
   );

   always_comb begin
      hcnt_inc     = sat_inc(hcnt);
      lcnt_inc     = sat_inc(lcnt);
      bit_val      = (hcnt >= THRESH);
      sh_next      = {shreg[22:0], bit_val};
      pix_done_now = (state == ST_HIGH) && !din_s && (hcnt >= MIN_H) && (bit_cnt == LAST_BIT);
      latch_now    = (state == ST_LOW) && !din_s && (lcnt_inc == RST_L);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_SYNC;
         hcnt         <= '0;
         lcnt         <= '0;
         pix_cnt      <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         pix_valid    <= 1'b0;
         pix_data     <= '0;
         pix_index    <= '0;
         frame_done   <= 1'b0;
         frame_pixels <= '0;
         bit_err      <= 1'b0;
         overflow     <= 1'b0;
      end else begin
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         bit_err    <= 1'b0;
         if (frame_done)
            overflow <= 1'b0;

         case (state)
            ST_SYNC: begin
               if (din_s) begin
                  lcnt <= '0;
               end else if (lcnt_inc == RST_L) begin
                  lcnt  <= '0;
                  state <= ST_IDLE;
               end else begin
                  lcnt <= lcnt_inc;
               end
            end

            ST_IDLE: begin
               if (din_s) begin
                  hcnt  <= CNT_W'(1);
                  state <= ST_HIGH;
               end
            end

            ST_HIGH: begin
               if (din_s) begin
                  // Stuck-high line: drop the partial word and re-acquire framing.
                  if (hcnt_inc == MAX_H1) begin
                     bit_err <= 1'b1;
                     bit_cnt <= '0;
                     shreg   <= '0;
                     lcnt    <= '0;
                     state   <= ST_SYNC;
                  end else begin
                     hcnt <= hcnt_inc;
                  end
               end else begin
                  lcnt  <= CNT_W'(1);
                  state <= ST_LOW;
                  if (hcnt < MIN_H) begin
                     bit_err <= 1'b1;
                  end else if (pix_done_now) begin
                     bit_cnt <= '0;
                     shreg   <= '0;
                     if (pix_cnt < MAXP) begin
                        pix_valid <= 1'b1;
                        pix_data  <= sh_next;
                        pix_index <= pix_cnt[7:0];
                        pix_cnt   <= pix_cnt + 1'b1;
                     end else begin
                        overflow <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                     shreg   <= sh_next;
                  end
               end
            end

            ST_LOW: begin
               if (din_s) begin
                  hcnt  <= CNT_W'(1);
                  state <= ST_HIGH;
               end else if (latch_now) begin
                  frame_done   <= 1'b1;
                  frame_pixels <= pix_cnt[7:0];
                  bit_err      <= (bit_cnt != '0);
                  bit_cnt      <= '0;
                  shreg        <= '0;
                  pix_cnt      <= '0;
                  lcnt         <= '0;
                  state        <= ST_IDLE;
               end else begin
                  lcnt <= lcnt_inc;
               end
            end

            default: state <= ST_SYNC;
         endcase
      end
   end

`ifdef WS2812_RX_FORWARD_EN
   logic pix0_done, fwd_en;

   // Forwarding opens the cycle after pixel 0 is consumed and closes on the latch.
   always_ff @(posedge clk) begin
      if (reset) begin
         pix0_done <= 1'b0;
         fwd_en    <= 1'b0;
      end else begin
         pix0_done <= pix_done_now && (pix_cnt == '0);
         if (latch_now || state == ST_SYNC)
            fwd_en <= 1'b0;
         else if (pix0_done)
            fwd_en <= 1'b1;
      end
   end

   assign dout = fwd_en & din_s;
`else
   assign dout = 1'b0;
`endif

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter T_THRESH_CLK, default 30: sync-high clocks at or above this decode as bit 1, below as bit 0.
REQ-002 Parameter T_MIN_HIGH_CLK, default 5: high pulses shorter than this are glitches.
REQ-003 Parameter T_MAX_HIGH_CLK, default 100: high pulses longer than this are errors.
REQ-004 Parameter T_RESET_CLK, default 2500: continuous low clocks that constitute a latch (50 us at 50 MHz).
REQ-005 Parameter MAX_PIXELS, default 109: highest pixel count reported per frame.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 din  input  1  asynchronous WS2812 one-wire serial stream (the LED line).
REQ-009 pix_valid  output  1  one-cycle strobe: pix_data/pix_index valid.
REQ-010 pix_data  output  24  received GRB word, G[23:16], R[15:8], B[7:0], first bit in bit 23.
REQ-011 pix_index  output  8  zero-based pixel position within the current frame.
REQ-012 frame_done  output  1  one-cycle strobe on latch detection.
REQ-013 frame_pixels  output  8  complete pixels counted in the finished frame; valid with frame_done.
REQ-014 bit_err  output  1  one-cycle strobe on any protocol error.
REQ-015 overflow  output  1  sticky: frame exceeded MAX_PIXELS; cleared at next frame_done+1 cycle.
REQ-016 dout  output  1  cascade output (see Configuration).

Function
REQ-017 din passes a two-flop synchronizer; all timing is counted on the synchronized signal (din_s), with 2-cycle input latency.
REQ-018 FSM states: SYNC, IDLE, HIGH, LOW.
REQ-019 SYNC: count din_s low clocks, restart on any high; on reaching T_RESET_CLK go IDLE, without frame_done.
REQ-020 IDLE: on din_s rising go HIGH with the high counter at 1.
REQ-021 HIGH: on falling edge, decide the bit from the high count, shift it in, and go LOW with the low counter at 1.
REQ-022 HIGH: a count < T_MIN_HIGH_CLK at falling edge pulses bit_err and shifts nothing.
REQ-023 HIGH: a count reaching T_MAX_HIGH_CLK + 1 pulses bit_err, discards the partial word, and goes SYNC.
REQ-024 LOW: on rising edge go HIGH.
REQ-025 LOW: on the low count reaching T_RESET_CLK, pulse frame_done, then go IDLE.
REQ-026 On the 24th shifted bit, pulse pix_valid in the cycle after the falling edge, provided the index is < MAX_PIXELS; then increment the pixel counter.
REQ-027 At the index limit, suppress pix_valid, set overflow, and hold the counter at MAX_PIXELS.
REQ-028 On latch with a nonzero partial bit count, pulse bit_err in the same cycle as frame_done and discard the partial.
REQ-029 frame_pixels equals the saturated pixel counter; the bit and pixel counters clear after frame_done.
REQ-030 Counters are 16-bit and saturating; no wrap-around.
REQ-031 pix_data and pix_index hold their last value between strobes.

Reset
REQ-032 reset forces state SYNC and clears every counter, shift register and output: pix_valid 0, pix_data 0, pix_index 0, frame_done 0, frame_pixels 0, bit_err 0, overflow 0, dout 0.
REQ-033 Reset mid-frame drops the partial frame silently, with no frame_done and no bit_err.

Configuration
REQ-034 With WS2812_RX_FORWARD_EN defined, dout equals din_s from the cycle after pixel 0's pix_valid (or its suppression) until frame_done, and is 0 otherwise, so the first pixel is consumed and the rest passed on, as a real LED does.
REQ-035 Without WS2812_RX_FORWARD_EN, dout is constant 0 and no forwarding logic is built.

Structure
REQ-036 Package ws2812_pkg holds the FSM state enum, GRB_BITS=24, and default timing constants shared with the transmitter side.
REQ-037 Sub-module sync_2ff implements the input synchronizer.
REQ-038 The remaining logic is flat in ws2812_rx.

Verification
REQ-039 Reset, then din low for 2500 clk, then 24 bits encoding 0x12AB34 (H1 40/L 22, H0 20/L 42), then low for 2500 clk -> pix_valid once with pix_data 0x12AB34 and pix_index 0, then frame_done with frame_pixels 1 and no bit_err.
REQ-040 Send 3 pixels, latch, then 2 pixels -> pix_index sequence 0,1,2 then 0,1; frame_pixels 3 then 2.
REQ-041 Set MAX_PIXELS=2, send 4 pixels -> 2 pix_valid strobes, overflow set, frame_pixels 2.
REQ-042 A 3-clk high glitch mid-word -> bit_err, and the word completes after 24 valid bits; a 150-clk high -> bit_err, state SYNC, and no output until 2500 clk low.
REQ-043 Send 10 bits then latch -> bit_err coincident with frame_done, frame_pixels 0; asserting reset mid-word -> no strobes.
REQ-044 With WS2812_RX_FORWARD_EN defined, send 2 pixels -> dout low during pixel 0 and reproducing pixel 1's waveform delayed by 2 clk relative to din.
